guess_entry_seq: RTL and testbench

//  Mastermind entry sequencer, directly upstream of the 3-to-8 slot-select decoder.

---
 rtl/guess_entry_seq.sv | 124 ++++++++++++
 tb/tb_guess_entry_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry_seq.sv
// Mastermind entry sequencer: steps through four colour slots for the secret, then the guesses,
// strobes slot writes to the decoder, and tracks rounds and the evaluator's verdict.
module guess_entry_seq #(
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned MAX_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear,
  input  logic               eval_ack,
  input  logic               eval_win,
  output logic               modo,
  output logic               s1,
  output logic               s0,
  output logic               wr_en,
  output logic [COLOR_W-1:0] wr_color,
  output logic               guess_done,
  output logic [3:0]         round,
  output logic               win,
  output logic               lose
);

  typedef enum logic [1:0] {StSecret, StGuess, StEval, StOver} state_e;

  localparam logic [3:0] LastRound = 4'(MAX_ROUNDS - 1);

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] round_q, round_d;
  logic       btn_q, btn_d;
  logic       modo_q, modo_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       press;
  logic       entry_st;

  assign press    = btn & ~btn_q;
  assign entry_st = (state_q == StSecret) || (state_q == StGuess);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    round_d    = round_q;
    win_d      = win_q;
    lose_d     = lose_q;
    btn_d      = btn;
    wr_en      = press & entry_st & ~clear & ~rst;
    guess_done = wr_en && (state_q == StGuess) && (slot_q == 2'd3);

    if (clear) begin
      state_d = StSecret;
      slot_d  = 2'd0;
      round_d = 4'd0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      btn_d   = 1'b0;
    end else begin
      unique case (state_q)
        StSecret: begin
          if (press) begin
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) state_d = StGuess;
          end
        end
        StGuess: begin
          if (press) begin
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) state_d = StEval;
          end
        end
        StEval: begin
          if (eval_ack) begin
            if (eval_win) begin
              state_d = StOver;
              win_d   = 1'b1;
            end else if (round_q == LastRound) begin
              // Final rejection: round holds at its saturated value.
              state_d = StOver;
              lose_d  = 1'b1;
            end else begin
              state_d = StGuess;
              round_d = round_q + 4'd1;
            end
          end
        end
        StOver: ;
        default: state_d = StSecret;
      endcase
    end

    modo_d = (state_d != StSecret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSecret;
      slot_q  <= 2'd0;
      round_q <= 4'd0;
      btn_q   <= 1'b0;
      modo_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      round_q <= round_d;
      btn_q   <= btn_d;
      modo_q  <= modo_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign modo     = modo_q;
  assign s1       = slot_q[1];
  assign s0       = slot_q[0];
  assign wr_color = color;
  assign round    = round_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_guess_entry_seq.sv
// Directed bench for guess_entry_seq: expected slot writes are queued as presses are driven
// and checked against every wr_en strobe; state outputs are checked at fixed points.
module tb_guess_entry_seq;

  logic       clk = 1'b0;
  logic       rst, btn, clear, eval_ack, eval_win;
  logic [2:0] color;
  logic       modo, s1, s0, wr_en, guess_done, win, lose;
  logic [2:0] wr_color;
  logic [3:0] round;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int gd_cnt = 0;

  logic [5:0] exp_q[$];  // {modo,s1,s0,color}
  logic       m_mode;
  logic [1:0] m_slot;

  guess_entry_seq #(.COLOR_W(3), .MAX_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .color     (color),
    .clear     (clear),
    .eval_ack  (eval_ack),
    .eval_win  (eval_win),
    .modo      (modo),
    .s1        (s1),
    .s0        (s0),
    .wr_en     (wr_en),
    .wr_color  (wr_color),
    .guess_done(guess_done),
    .round     (round),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [5:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", {26'd0, modo, s1, s0, wr_color}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr_color", {26'd0, modo, s1, s0, wr_color}, {26'd0, e});
        chk("guess_done", {31'd0, guess_done}, {31'd0, (e[5:3] == 3'b111)});
      end
    end
    if (guess_done === 1'b1) gd_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [2:0] c);
    exp_q.push_back({m_mode, m_slot, c});
    if (m_slot == 2'd3) m_mode = 1'b1;
    m_slot = m_slot + 2'd1;
  endtask

  // One press: high for one cycle, low for one cycle.
  task automatic press(input logic [2:0] c, input bit writes);
    if (writes) expect_write(c);
    btn   = 1'b1;
    color = c;
    cyc();
    btn = 1'b0;
    cyc();
  endtask

  task automatic ack(input logic w);
    eval_ack = 1'b1;
    eval_win = w;
    cyc();
    eval_ack = 1'b0;
    eval_win = 1'b0;
    cyc();
  endtask

  task automatic chk_pos(input string tag, input logic [2:0] addr);
    @(negedge clk);
    chk(tag, {29'd0, modo, s1, s0}, {29'd0, addr});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear  = 1'b0;
    m_mode = 1'b0;
    m_slot = 2'd0;
  endtask

  initial begin
    int w0;
    rst = 1'b1; btn = 1'b0; clear = 1'b0; eval_ack = 1'b0; eval_win = 1'b0; color = 3'd0;
    m_mode = 1'b0; m_slot = 2'd0;

    // Reset, with a button press that must not write
    cyc();
    btn = 1'b1;
    @(negedge clk);
    chk("wr_en_in_reset", {31'd0, wr_en}, 32'd0);
    cyc();
    btn = 1'b0;
    rst = 1'b0;
    cyc();
    chk_pos("reset_pos", 3'b000);
    chk("reset_round", {28'd0, round}, 32'd0);
    chk("reset_win_lose", {30'd0, win, lose}, 32'd0);

    // Secret entry
    for (int i = 1; i <= 4; i++) press(3'(i), 1'b1);
    chk_pos("after_secret", 3'b100);

    // Held button gives one write
    w0 = wr_cnt;
    expect_write(3'd5);
    btn = 1'b1; color = 3'd5;
    repeat (20) cyc();
    btn = 1'b0;
    cyc();
    chk("held_one_write", wr_cnt - w0, 32'd1);
    chk_pos("held_slot", 3'b101);

    // Finish guess, press in EVAL ignored, win
    press(3'd6, 1'b1);
    press(3'd7, 1'b1);
    press(3'd0, 1'b1);
    chk("guess_done_count", gd_cnt, 32'd1);
    chk_pos("eval_pos", 3'b100);
    w0 = wr_cnt;
    press(3'd3, 1'b0);
    chk("eval_no_write", wr_cnt - w0, 32'd0);
    ack(1'b1);
    @(negedge clk);
    chk("win_set", {30'd0, win, lose}, 32'b10);
    press(3'd2, 1'b0);
    ack(1'b0);
    @(negedge clk);
    chk("over_hold", {26'd0, win, lose, round}, {26'd0, 2'b10, 4'd0});

    // Loss after ten rejected guesses
    do_clear();
    @(negedge clk);
    chk("clear_state", {25'd0, modo, s1, s0, win, lose, round[1:0]}, 32'd0);
    for (int i = 0; i < 4; i++) press(3'(i + 2), 1'b1);
    ack(1'b0);  // ignored outside EVAL
    @(negedge clk);
    chk("ack_outside_eval", {28'd0, round}, 32'd0);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) press(3'((r + i) % 8), 1'b1);
      @(negedge clk);
      chk("round_before_ack", {28'd0, round}, r);
      ack(1'b0);
      @(negedge clk);
      if (r < 9) begin
        chk("round_after_ack", {27'd0, lose, round}, {27'd0, 1'b0, 4'(r + 1)});
      end else begin
        chk("lose_final", {26'd0, win, lose, round}, {26'd0, 2'b01, 4'd9});
      end
    end

    // clear beats press in the same cycle
    do_clear();
    for (int i = 0; i < 4; i++) press(3'd1, 1'b1);
    for (int i = 0; i < 4; i++) press(3'd2, 1'b1);
    ack(1'b0);
    @(negedge clk);
    chk("round_one", {28'd0, round}, 32'd1);
    press(3'd4, 1'b1);
    press(3'd5, 1'b1);
    chk_pos("guess_slot2", 3'b110);
    w0 = wr_cnt;
    clear = 1'b1; btn = 1'b1; color = 3'd6;
    @(negedge clk);
    chk("clear_press_wr_en", {31'd0, wr_en}, 32'd0);
    cyc();
    clear = 1'b0; btn = 1'b0;
    m_mode = 1'b0; m_slot = 2'd0;
    @(negedge clk);
    chk("clear_press_state", {25'd0, modo, s1, s0, round}, 32'd0);
    chk("clear_press_no_write", wr_cnt - w0, 32'd0);
    cyc();
    press(3'd7, 1'b1);
    chk_pos("after_clear_entry", 3'b001);

    cyc();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
